// File: rtl/regfile_dump_sequencer_pkg.sv
// Shared definitions for the debug-unit dump sequencers: FSM encoding and
// byte-channel geometry.
package regfile_dump_sequencer_pkg;

  localparam int unsigned NB_BYTE = 8;

  typedef enum logic [2:0] {
    StIdle,
    StWaitHalt,
    StRead,
    StSend,
    StDone
  } state_e;

  function automatic int unsigned bytes_per_word(input int unsigned nb_data,
                                                 input int unsigned nb_byte);
    return nb_data / nb_byte;
  endfunction

  localparam int unsigned BYTES_PER_WORD = bytes_per_word(32, NB_BYTE);

endpackage

// File: rtl/regfile_dump_sequencer_if.sv
// Byte-wide valid/ready channel from a dump sequencer to the UART TX path.
interface regfile_dump_sequencer_if #(
  parameter int unsigned NB_BYTE = 8
);

  logic [NB_BYTE-1:0] tx_byte;
  logic               tx_valid;
  logic               tx_ready;

  modport master (
    output tx_byte,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_byte,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/regfile_dump_sequencer_serializer.sv
// Loads a word and streams it MSB-first as bytes over a valid/ready channel.
// Shared by the register-file, PC and data-memory dump paths.
module word_byte_serializer #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_BYTE = 8
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_load,
  input  logic [NB_DATA-1:0]   i_word,
  regfile_dump_sequencer_if.master tx,
  output logic                 o_last_accepted
);

  import regfile_dump_sequencer_pkg::*;

  localparam int unsigned BPW    = bytes_per_word(NB_DATA, NB_BYTE);
  localparam int unsigned NB_CNT = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(BPW - 1);

  logic [NB_DATA-1:0] shreg_q, shreg_d;
  logic [NB_CNT-1:0]  cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               accept;
  logic               last;

  assign accept = valid_q & tx.tx_ready;
  assign last   = (cnt_q == LAST_CNT);

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (i_load) begin
      shreg_d = i_word;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (accept) begin
      if (last) begin
        valid_d = 1'b0;
      end else begin
        shreg_d = shreg_q << NB_BYTE;
        cnt_d   = cnt_q + NB_CNT'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  // The byte is a direct slice of the held register, so it cannot change while
  // valid is up and the word has not been accepted.
  assign tx.tx_valid     = valid_q;
  assign tx.tx_byte      = shreg_q[NB_DATA-1 -: NB_BYTE];
  assign o_last_accepted = accept & last;

endmodule

// File: rtl/regfile_dump_sequencer.sv
// Debug controller that borrows register-file read port 1 while the pipeline
// is halted and streams every register, MSB first, to the UART TX path.
module regfile_dump_sequencer #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ADDR = 5,
  parameter int unsigned NB_BYTE = regfile_dump_sequencer_pkg::NB_BYTE
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_halted,
  input  logic [NB_ADDR-1:0] i_pipe_rd_addr,
  output logic [NB_ADDR-1:0] o_rf_rd_addr,
  input  logic [NB_DATA-1:0] i_rf_rd_data,
  regfile_dump_sequencer_if.master tx,
  output logic               o_busy,
  output logic               o_done
);

  import regfile_dump_sequencer_pkg::*;

  localparam logic [NB_ADDR-1:0] LAST_IDX = '1;

  state_e             state_q, state_d;
  logic [NB_ADDR-1:0] idx_q, idx_d;
  logic               load;
  logic               last_accepted;

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          idx_d   = '0;
          state_d = StWaitHalt;
        end
      end
      StWaitHalt: begin
        if (i_halted) state_d = StRead;
      end
      // Losing halt here keeps idx, so the dump resumes at the same register.
      StRead: begin
        state_d = i_halted ? StSend : StWaitHalt;
      end
      StSend: begin
        if (last_accepted) begin
          if (idx_q == LAST_IDX) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + NB_ADDR'(1);
            state_d = StRead;
          end
        end
      end
      StDone: begin
        idx_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    load         = 1'b0;
    o_done       = 1'b0;
    o_busy       = 1'b1;
    o_rf_rd_addr = idx_q;
    unique case (state_q)
      StIdle: begin
        o_busy       = 1'b0;
        o_rf_rd_addr = i_pipe_rd_addr;
      end
      StWaitHalt: o_rf_rd_addr = i_pipe_rd_addr;
      StRead:     load = i_halted;
      StSend:     o_rf_rd_addr = idx_q;
      StDone:     o_done = 1'b1;
      default: begin
        o_busy       = 1'b0;
        o_rf_rd_addr = i_pipe_rd_addr;
      end
    endcase
  end

  word_byte_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_serializer (
    .clk             (clk),
    .i_reset         (i_reset),
    .i_load          (load),
    .i_word          (i_rf_rd_data),
    .tx              (tx),
    .o_last_accepted (last_accepted)
  );

endmodule

// File: tb/tb_regfile_dump_sequencer.sv
// Directed + randomized bench for regfile_dump_sequencer against a byte-stream
// model of the register file contents.
module tb_regfile_dump_sequencer;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic        i_halted;
  logic [4:0]  i_pipe_rd_addr;
  logic [4:0]  o_rf_rd_addr;
  logic [31:0] i_rf_rd_data;
  logic        o_busy;
  logic        o_done;

  regfile_dump_sequencer_if #(.NB_BYTE(8)) tx ();

  logic [31:0] rf [32];
  assign i_rf_rd_data = rf[o_rf_rd_addr];

  always #5 clk = ~clk;

  regfile_dump_sequencer #(
    .NB_DATA (32),
    .NB_ADDR (5),
    .NB_BYTE (8)
  ) dut (
    .clk            (clk),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_halted       (i_halted),
    .i_pipe_rd_addr (i_pipe_rd_addr),
    .o_rf_rd_addr   (o_rf_rd_addr),
    .i_rf_rd_data   (i_rf_rd_data),
    .tx             (tx),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: samples just before each rising edge, when inputs are settled.
  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  int         mcyc = 0;
  int         start_cyc, first_acc_cyc, last_acc_cyc, done_cyc;
  int         done_cnt = 0;
  bit         hold_pend = 1'b0;
  logic [7:0] held;

  always begin
    @(negedge clk);
    #3;
    if (!i_reset) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 64'(tx.tx_valid), 64'(1));
        check("hold_byte", 64'(tx.tx_byte), 64'(held));
      end
      hold_pend = tx.tx_valid && !tx.tx_ready;
      held      = tx.tx_byte;
      if (i_start && !o_busy) start_cyc = mcyc;
      if (tx.tx_valid && tx.tx_ready) begin
        if (got.size() == 0) first_acc_cyc = mcyc;
        got.push_back(tx.tx_byte);
        last_acc_cyc = mcyc;
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = mcyc;
      end
    end
    mcyc++;
  end

  task automatic clear_mon();
    got.delete();
    done_cnt = 0;
  endtask

  task automatic fill_random();
    for (int k = 0; k < 32; k++) rf[k] = $urandom;
  endtask

  // Expected stream: every register in address order, most significant byte first.
  task automatic compare_stream(input string tag);
    exp_q.delete();
    for (int k = 0; k < 32; k++)
      for (int b = 0; b < 4; b++) exp_q.push_back(rf[k][31-8*b -: 8]);
    check($sformatf("%s_count", tag), 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit rnd_ready, input bit spam_start);
    bit seen = 1'b0;
    int n    = 0;
    while (!seen && n < 2000) begin
      @(negedge clk);
      n++;
      if (o_done) begin
        seen = 1'b1;
      end else begin
        if (rnd_ready) tx.tx_ready = 1'($urandom_range(0, 1));
        if (spam_start) i_start = ($urandom_range(0, 5) == 0);
      end
    end
    i_start     = 1'b0;
    tx.tx_ready = 1'b1;
    check($sformatf("%s_done_seen", tag), 64'(seen), 64'(1));
  endtask

  initial begin
    bit found;
    i_reset        = 1'b0;
    i_start        = 1'b0;
    i_halted       = 1'b1;
    i_pipe_rd_addr = 5'd0;
    tx.tx_ready    = 1'b1;
    for (int k = 0; k < 32; k++) rf[k] = 32'h0A0B0C00 + k;

    #1;
    check("rst_valid", 64'(tx.tx_valid), 64'(0));
    check("rst_byte", 64'(tx.tx_byte), 64'(0));
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_done", 64'(o_done), 64'(0));
    repeat (2) @(negedge clk);
    i_reset        = 1'b1;
    i_pipe_rd_addr = 5'd13;
    #1;
    check("idle_passthru", 64'(o_rf_rd_addr), 64'(13));

    // Full dump of the 0A0B0C00+k pattern with ready held high.
    clear_mon();
    pulse_start();
    wait_done("t1", 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("t1_busy_after", 64'(o_busy), 64'(0));
    check("t1_done_pulse", 64'(o_done), 64'(0));
    compare_stream("t1");
    check("t1_first_lat", 64'(first_acc_cyc - start_cyc), 64'(3));
    check("t1_done_after_last", 64'(done_cyc - last_acc_cyc), 64'(1));
    check("t1_total_lat", 64'(done_cyc - start_cyc), 64'(162));
    check("t1_done_cnt", 64'(done_cnt), 64'(1));

    // Random contents, random back-pressure; reg[3] carries DEADBEEF.
    fill_random();
    rf[3] = 32'hDEADBEEF;
    clear_mon();
    pulse_start();
    wait_done("t2", 1'b1, 1'b0);
    @(negedge clk);
    compare_stream("t2");
    check("t2_done_cnt", 64'(done_cnt), 64'(1));

    // Start while not halted: parks in WAIT_HALT with address passthrough.
    fill_random();
    clear_mon();
    i_halted       = 1'b0;
    i_pipe_rd_addr = 5'd7;
    pulse_start();
    repeat (4) @(negedge clk);
    #1;
    check("t3_busy", 64'(o_busy), 64'(1));
    check("t3_no_valid", 64'(tx.tx_valid), 64'(0));
    check("t3_passthru7", 64'(o_rf_rd_addr), 64'(7));
    i_pipe_rd_addr = 5'd19;
    #1;
    check("t3_passthru19", 64'(o_rf_rd_addr), 64'(19));
    @(negedge clk);
    i_halted = 1'b1;
    @(negedge clk);
    #1;
    check("t3_read_valid", 64'(tx.tx_valid), 64'(0));
    check("t3_read_addr", 64'(o_rf_rd_addr), 64'(0));
    @(negedge clk);
    #1;
    check("t3_first_valid", 64'(tx.tx_valid), 64'(1));
    check("t3_first_byte", 64'(tx.tx_byte), 64'(rf[0][31:24]));
    wait_done("t3", 1'b0, 1'b0);
    @(negedge clk);
    compare_stream("t3");

    // Drop halt in READ for idx 4, then resume.
    fill_random();
    clear_mon();
    i_pipe_rd_addr = 5'd22;
    pulse_start();
    found = 1'b0;
    for (int n = 0; n < 500 && !found; n++) begin
      @(negedge clk);
      if (o_busy && !tx.tx_valid && o_rf_rd_addr == 5'd4) begin
        found    = 1'b1;
        i_halted = 1'b0;
      end
    end
    check("t4_found_read4", 64'(found), 64'(1));
    repeat (3) begin
      @(negedge clk);
      #1;
      check("t4_no_valid", 64'(tx.tx_valid), 64'(0));
      check("t4_passthru", 64'(o_rf_rd_addr), 64'(22));
      check("t4_busy", 64'(o_busy), 64'(1));
    end
    check("t4_bytes_before", 64'(got.size()), 64'(16));
    i_halted = 1'b1;
    wait_done("t4", 1'b0, 1'b0);
    @(negedge clk);
    compare_stream("t4");

    // Asynchronous reset after byte 50, then a clean restart.
    fill_random();
    clear_mon();
    pulse_start();
    found = 1'b0;
    for (int n = 0; n < 500 && !found; n++) begin
      @(negedge clk);
      if (got.size() >= 50) found = 1'b1;
    end
    check("t5_reached50", 64'(found), 64'(1));
    #2;
    i_reset = 1'b0;
    #1;
    check("t5_rst_valid", 64'(tx.tx_valid), 64'(0));
    check("t5_rst_busy", 64'(o_busy), 64'(0));
    check("t5_rst_done", 64'(o_done), 64'(0));
    check("t5_rst_byte", 64'(tx.tx_byte), 64'(0));
    repeat (2) @(negedge clk);
    i_reset = 1'b1;
    clear_mon();
    pulse_start();
    wait_done("t5", 1'b0, 1'b0);
    @(negedge clk);
    compare_stream("t5");

    // Start pulses while busy are ignored.
    fill_random();
    clear_mon();
    pulse_start();
    wait_done("t6", 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    #1;
    compare_stream("t6");
    check("t6_done_cnt", 64'(done_cnt), 64'(1));
    check("t6_busy_after", 64'(o_busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
